nibble_serial_adder: RTL

//  Multi-cycle signed two's-complement adder for WIDTH-bit operands, built on one 4-bit adder slice.

---
 rtl/adder_pkg.sv | 13 +
 rtl/nibble_adder_cin.sv | 26 ++
 rtl/nibble_serial_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types for the nibble-serial adder.
// Holds the slice width and the FSM state encoding.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// Combinational 4-bit signed adder slice with carry-in.
// Overflow is the XOR of the carries into and out of bit 3.
module nibble_adder_cin
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                overflow
);

  logic [NIBBLE_W-1:0] lo;
  logic [1:0]          hi;
  logic                c3;

  assign lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3 = lo[3];
  assign hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};

  assign sum      = {hi[0], lo[2:0]};
  assign cout     = hi[1];
  assign overflow = c3 ^ hi[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle signed adder: one nibble per clock, LSB first,
// through a single shared 4-bit slice, with valid/ready handshakes.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             cout,
  output logic             busy
);

  import adder_pkg::*;

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = $clog2(NIBBLES) + 1;
  localparam int SW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t state, state_nx;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]       idx;
  logic [SW-1:0]       sel;
  logic                carry;
  logic                ovf_q;
  logic                cout_q;
  logic                last;
  logic [NIBBLE_W-1:0] s_sum;
  logic                s_cout;
  logic                s_ovf;

  assign sel  = idx[SW-1:0];
  assign last = (idx == IW'(NIBBLES - 1));

  nibble_adder_cin u_slice (
    .a        (a_q[sel]),
    .b        (b_q[sel]),
    .cin      (carry),
    .sum      (s_sum),
    .cout     (s_cout),
    .overflow (s_ovf)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q[sel] <= s_sum;
          carry      <= s_cout;
          idx        <= idx + 1'b1;
          if (last) begin
            ovf_q  <= s_ovf;
            cout_q <= s_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign cout      = cout_q;

endmodule
